// File: rtl/grid_update.sv
// grid_update: kitchen object grid, per-frame player edits plus chop,
// cook, burn and extinguish timers. All state moves on negedge vsync.
// Ports: vsync (clock), reset (sync, high), player_state, x_front,
// y_front in; object_grid [row][col], served_count, fire_alarm out.
// Macro GRID_FIRE_EN enables burning, extinguishing and fire_alarm.

package grid_pkg;
  localparam logic [3:0] P_NOTHING       = 4'd0;
  localparam logic [3:0] P_ONION_WHOLE   = 4'd1;
  localparam logic [3:0] P_ONION_CHOPPED = 4'd2;
  localparam logic [3:0] P_POT_EMPTY     = 4'd3;
  localparam logic [3:0] P_POT_RAW       = 4'd4;
  localparam logic [3:0] P_POT_COOKED    = 4'd5;
  localparam logic [3:0] P_BOWL_EMPTY    = 4'd6;
  localparam logic [3:0] P_BOWL_FULL     = 4'd7;
  localparam logic [3:0] P_EXT_OFF       = 4'd8;
  localparam logic [3:0] P_EXT_ON        = 4'd9;
  localparam logic [3:0] P_CHOPPING      = 4'd10;

  localparam logic [3:0] G_EMPTY         = 4'd0;
  localparam logic [3:0] G_ONION_WHOLE   = 4'd1;
  localparam logic [3:0] G_ONION_CHOPPED = 4'd2;
  localparam logic [3:0] G_POT_EMPTY     = 4'd3;
  localparam logic [3:0] G_POT_RAW       = 4'd4;
  localparam logic [3:0] G_POT_COOKED    = 4'd5;
  localparam logic [3:0] G_BOWL_EMPTY    = 4'd6;
  localparam logic [3:0] G_BOWL_FULL     = 4'd7;
  localparam logic [3:0] G_EXTINGUISHER  = 4'd8;
  localparam logic [3:0] G_POT_FIRE      = 4'd9;
  localparam logic [3:0] G_FIRE          = 4'd10;
endpackage

module grid_update
  import grid_pkg::*;
#(
  parameter int unsigned CHOP_FRAMES = 120,
  parameter int unsigned COOK_FRAMES = 300,
  parameter int unsigned BURN_FRAMES = 600,
  parameter int unsigned EXT_FRAMES  = 60,
  parameter int unsigned STOVE_X     = 6,
  parameter int unsigned STOVE_Y     = 0,
  parameter int unsigned SERVE_X     = 12,
  parameter int unsigned SERVE_Y     = 3
) (
  input  logic                    vsync,
  input  logic                    reset,
  input  logic [3:0]              player_state,
  input  logic [3:0]              x_front,
  input  logic [2:0]              y_front,
  output logic [7:0][12:0][3:0]   object_grid,
  output logic [7:0]              served_count,
  output logic                    fire_alarm
);

  localparam logic [3:0] SX = 4'(STOVE_X);
  localparam logic [2:0] SY = 3'(STOVE_Y);
  localparam logic [3:0] VX = 4'(SERVE_X);
  localparam logic [2:0] VY = 3'(SERVE_Y);

  localparam logic [9:0] CHOP_LAST = 10'(CHOP_FRAMES - 1);
  localparam logic [9:0] COOK_LAST = 10'(COOK_FRAMES - 1);
  localparam logic [9:0] BURN_LAST = 10'(BURN_FRAMES - 1);
  localparam logic [5:0] EXT_LAST  = 6'(EXT_FRAMES - 1);

`ifdef GRID_FIRE_EN
  localparam bit FIRE_EN = 1'b1;
`else
  localparam bit FIRE_EN = 1'b0;
`endif

  // Without burning the cook timer parks once the pot is cooked.
  localparam logic [9:0] COOK_SAT =
    FIRE_EN ? 10'(BURN_FRAMES) : 10'(COOK_FRAMES);

  function automatic logic [7:0][12:0][3:0] reset_grid();
    logic [7:0][12:0][3:0] g;
    g = '0;
    g[0][1]   = G_ONION_WHOLE;
    g[0][2]   = G_BOWL_EMPTY;
    g[SY][SX] = G_POT_EMPTY;
    g[7][12]  = G_EXTINGUISHER;
    return g;
  endfunction

  // Grid code for a carried item; EXT_ON is still the extinguisher.
  function automatic logic [3:0] carry_to_grid(input logic [3:0] p);
    logic [3:0] g;
    case (p)
      P_ONION_WHOLE:   g = G_ONION_WHOLE;
      P_ONION_CHOPPED: g = G_ONION_CHOPPED;
      P_POT_EMPTY:     g = G_POT_EMPTY;
      P_POT_RAW:       g = G_POT_RAW;
      P_POT_COOKED:    g = G_POT_COOKED;
      P_BOWL_EMPTY:    g = G_BOWL_EMPTY;
      P_BOWL_FULL:     g = G_BOWL_FULL;
      P_EXT_OFF:       g = G_EXTINGUISHER;
      P_EXT_ON:        g = G_EXTINGUISHER;
      default:         g = G_EMPTY;
    endcase
    return g;
  endfunction

  function automatic logic is_carry(input logic [3:0] p);
    return (p >= P_ONION_WHOLE) && (p <= P_EXT_ON);
  endfunction

  function automatic logic is_pick(input logic [3:0] p);
    return (p >= P_ONION_WHOLE) && (p <= P_EXT_OFF);
  endfunction

  logic [3:0] prev_state;
  logic [3:0] prev_x;
  logic [2:0] prev_y;
  logic [9:0] chop_cnt;
  logic [9:0] cook_cnt;
  logic [5:0] ext_cnt;

  logic       f_valid;
  logic [3:0] f_cell;
  logic [3:0] stove;
  logic       at_serve;
  logic       moved;

  assign f_valid  = (x_front <= 4'd12);
  assign f_cell   = f_valid ? object_grid[y_front][x_front]
                            : G_EMPTY;
  assign stove    = object_grid[SY][SX];
  assign at_serve = (x_front == VX) && (y_front == VY);
  assign moved    = (x_front != prev_x) || (y_front != prev_y);

  logic do_pick;
  logic do_drop;
  logic do_fill;
  logic do_scoop;
  logic do_pour;

  assign do_pick = f_valid
    && (prev_state == P_NOTHING)
    && is_pick(player_state)
    && (f_cell == carry_to_grid(player_state));
  assign do_drop = f_valid
    && (player_state == P_NOTHING)
    && is_carry(prev_state)
    && (f_cell == G_EMPTY);
  assign do_fill = f_valid
    && (prev_state == P_POT_EMPTY)
    && (player_state == P_POT_RAW)
    && (f_cell == G_ONION_CHOPPED);
  assign do_scoop = f_valid
    && (prev_state == P_BOWL_EMPTY)
    && (player_state == P_BOWL_FULL)
    && (f_cell == G_POT_COOKED);
  assign do_pour = f_valid
    && (prev_state == P_POT_COOKED)
    && (player_state == P_POT_EMPTY)
    && (f_cell == G_BOWL_EMPTY);

  logic       pw_en;
  logic [3:0] pw_val;
  logic       serve;

  always_comb begin
    pw_en  = 1'b0;
    pw_val = G_EMPTY;
    serve  = 1'b0;
    unique case (1'b1)
      do_pick: pw_en = 1'b1;
      do_drop: begin
        // A full bowl at the window is consumed, not placed.
        if (at_serve && (prev_state == P_BOWL_FULL)) begin
          serve = 1'b1;
        end else begin
          pw_en  = 1'b1;
          pw_val = carry_to_grid(prev_state);
        end
      end
      do_fill: pw_en = 1'b1;
      do_scoop: begin
        pw_en  = 1'b1;
        pw_val = G_POT_EMPTY;
      end
      do_pour: begin
        pw_en  = 1'b1;
        pw_val = G_BOWL_FULL;
      end
      default: ;
    endcase
  end

  logic chop_run;
  logic chop_hit;
  logic ext_run;
  logic ext_hit;
  logic cook_run;
  logic cook_done;
  logic burn_hit;

  assign chop_run = f_valid && !moved
    && (player_state == P_CHOPPING)
    && (f_cell == G_ONION_WHOLE);
  assign chop_hit = chop_run && (chop_cnt == CHOP_LAST);

`ifdef GRID_FIRE_EN
  assign ext_run = f_valid
    && (player_state == P_EXT_ON)
    && ((f_cell == G_POT_FIRE) || (f_cell == G_FIRE));
`else
  assign ext_run = 1'b0;
`endif
  assign ext_hit = ext_run && (ext_cnt == EXT_LAST);

  assign cook_run  = (stove == G_POT_RAW)
                  || (stove == G_POT_COOKED);
  assign cook_done = cook_run && (stove == G_POT_RAW)
                  && (cook_cnt == COOK_LAST);
  assign burn_hit  = FIRE_EN && cook_run
                  && (cook_cnt == BURN_LAST);

  logic chop_lose;
  logic ext_lose;
  logic cook_lose;

  assign ext_lose  = ext_hit && pw_en;
  assign chop_lose = chop_hit && (pw_en || ext_hit);
  assign cook_lose = (cook_done || burn_hit)
                  && (pw_en || ext_hit || chop_hit);

  logic       wr_en;
  logic [3:0] wr_x;
  logic [2:0] wr_y;
  logic [3:0] wr_val;

  always_comb begin
    wr_en  = 1'b0;
    wr_x   = x_front;
    wr_y   = y_front;
    wr_val = G_EMPTY;
    if (pw_en) begin
      wr_en  = 1'b1;
      wr_val = pw_val;
    end else if (ext_hit) begin
      wr_en  = 1'b1;
      wr_val = (f_cell == G_POT_FIRE) ? G_POT_EMPTY : G_EMPTY;
    end else if (chop_hit) begin
      wr_en  = 1'b1;
      wr_val = G_ONION_CHOPPED;
    end else if (cook_done) begin
      wr_en  = 1'b1;
      wr_x   = SX;
      wr_y   = SY;
      wr_val = G_POT_COOKED;
    end else if (burn_hit) begin
      wr_en  = 1'b1;
      wr_x   = SX;
      wr_y   = SY;
      wr_val = G_POT_FIRE;
    end
  end

  logic [9:0] chop_nxt;
  logic [9:0] cook_nxt;
  logic [5:0] ext_nxt;

  // A timer whose write lost arbitration holds and retries next frame.
  always_comb begin
    chop_nxt = '0;
    if (chop_run) begin
      if (chop_lose)     chop_nxt = chop_cnt;
      else if (chop_hit) chop_nxt = '0;
      else               chop_nxt = chop_cnt + 10'd1;
    end
  end

  always_comb begin
    ext_nxt = '0;
    if (ext_run) begin
      if (ext_lose)     ext_nxt = ext_cnt;
      else if (ext_hit) ext_nxt = '0;
      else              ext_nxt = ext_cnt + 6'd1;
    end
  end

  always_comb begin
    cook_nxt = '0;
    if (cook_run) begin
      if (cook_lose || (cook_cnt >= COOK_SAT))
        cook_nxt = cook_cnt;
      else
        cook_nxt = cook_cnt + 10'd1;
    end
  end

  // Alarm tracks the stove value being registered this edge.
  logic [3:0] stove_nxt;

  assign stove_nxt = (wr_en && (wr_x == SX) && (wr_y == SY))
                   ? wr_val : stove;

  always_ff @(negedge vsync) begin
    if (reset) begin
      object_grid  <= reset_grid();
      served_count <= '0;
      fire_alarm   <= 1'b0;
      prev_state   <= P_NOTHING;
      prev_x       <= '0;
      prev_y       <= '0;
      chop_cnt     <= '0;
      cook_cnt     <= '0;
      ext_cnt      <= '0;
    end else begin
      if (wr_en)
        object_grid[wr_y][wr_x] <= wr_val;
      if (serve && (served_count != 8'hff))
        served_count <= served_count + 8'd1;
      fire_alarm <= FIRE_EN && (stove_nxt == G_POT_FIRE);
      prev_state <= player_state;
      prev_x     <= x_front;
      prev_y     <= y_front;
      chop_cnt   <= chop_nxt;
      cook_cnt   <= cook_nxt;
      ext_cnt    <= ext_nxt;
    end
  end

endmodule

// File: tb/tb_grid_update.sv
// Bench for grid_update: directed scenarios plus random frames,
// checked every frame against a behavioural grid model.

module tb_grid_update;
  import grid_pkg::*;

  localparam int CHOP = 120;
  localparam int COOK = 300;
  localparam int BURN = 600;
  localparam int EXT  = 60;
  localparam int SX   = 6;
  localparam int SY   = 0;
  localparam int VX   = 12;
  localparam int VY   = 3;
`ifdef GRID_FIRE_EN
  localparam bit FIRE = 1'b1;
`else
  localparam bit FIRE = 1'b0;
`endif
  localparam int SAT = FIRE ? BURN : COOK;

  logic                  vsync = 1'b0;
  logic                  reset = 1'b1;
  logic [3:0]            player_state = '0;
  logic [3:0]            x_front = '0;
  logic [2:0]            y_front = '0;
  logic [7:0][12:0][3:0] object_grid;
  logic [7:0]            served_count;
  logic                  fire_alarm;

  grid_update dut (
    .vsync(vsync),
    .reset(reset),
    .player_state(player_state),
    .x_front(x_front),
    .y_front(y_front),
    .object_grid(object_grid),
    .served_count(served_count),
    .fire_alarm(fire_alarm)
  );

  always #5 vsync = ~vsync;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  // Model state
  int g[8][13];
  int m_served, m_prev, m_px, m_py;
  int m_chop, m_cook, m_ext;
  bit m_alarm;

  function automatic int carry_g(int p);
    case (p)
      P_ONION_WHOLE:   return G_ONION_WHOLE;
      P_ONION_CHOPPED: return G_ONION_CHOPPED;
      P_POT_EMPTY:     return G_POT_EMPTY;
      P_POT_RAW:       return G_POT_RAW;
      P_POT_COOKED:    return G_POT_COOKED;
      P_BOWL_EMPTY:    return G_BOWL_EMPTY;
      P_BOWL_FULL:     return G_BOWL_FULL;
      P_EXT_OFF:       return G_EXTINGUISHER;
      P_EXT_ON:        return G_EXTINGUISHER;
      default:         return -1;
    endcase
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 13; c++)
        g[r][c] = G_EMPTY;
    g[0][1]   = G_ONION_WHOLE;
    g[0][2]   = G_BOWL_EMPTY;
    g[SY][SX] = G_POT_EMPTY;
    g[7][12]  = G_EXTINGUISHER;
    m_served = 0; m_prev = P_NOTHING;
    m_px = 0; m_py = 0;
    m_chop = 0; m_cook = 0; m_ext = 0;
    m_alarm = 1'b0;
  endtask

  task automatic model_step();
    int ps, x, y, f, wv, nxt;
    int o_chop, o_cook, o_ext;
    bit valid, pw, srv, hit_x, hit_c, hit_k, hit_b, st;
    if (reset) begin
      model_reset();
      return;
    end
    ps = player_state; x = x_front; y = y_front;
    valid = (x <= 12);
    f = -1;
    if (valid) f = g[y][x];
    pw = 0; srv = 0; wv = G_EMPTY;
    if (valid) begin
      if (m_prev == P_NOTHING && ps != P_EXT_ON
          && carry_g(ps) >= 0 && f == carry_g(ps)) begin
        pw = 1; wv = G_EMPTY;
      end else if (ps == P_NOTHING && carry_g(m_prev) >= 0
                   && f == G_EMPTY) begin
        if (x == VX && y == VY && m_prev == P_BOWL_FULL)
          srv = 1;
        else begin
          pw = 1; wv = carry_g(m_prev);
        end
      end else if (m_prev == P_POT_EMPTY && ps == P_POT_RAW
                   && f == G_ONION_CHOPPED) begin
        pw = 1; wv = G_EMPTY;
      end else if (m_prev == P_BOWL_EMPTY && ps == P_BOWL_FULL
                   && f == G_POT_COOKED) begin
        pw = 1; wv = G_POT_EMPTY;
      end else if (m_prev == P_POT_COOKED && ps == P_POT_EMPTY
                   && f == G_BOWL_EMPTY) begin
        pw = 1; wv = G_BOWL_FULL;
      end
    end
    o_chop = m_chop; o_cook = m_cook; o_ext = m_ext;
    // consecutive chopping frames at one spot
    if (valid && x == m_px && y == m_py
        && ps == P_CHOPPING && f == G_ONION_WHOLE) m_chop++;
    else m_chop = 0;
    hit_c = (m_chop == CHOP);
    if (FIRE && valid && ps == P_EXT_ON
        && (f == G_POT_FIRE || f == G_FIRE)) m_ext++;
    else m_ext = 0;
    hit_x = (m_ext == EXT);
    st = (g[SY][SX] == G_POT_RAW || g[SY][SX] == G_POT_COOKED);
    hit_k = 0; hit_b = 0;
    if (st) begin
      nxt = m_cook + 1;
      hit_k = (g[SY][SX] == G_POT_RAW) && nxt == COOK;
      hit_b = FIRE && nxt == BURN;
      m_cook = (nxt > SAT) ? SAT : nxt;
    end else m_cook = 0;
    if (pw) begin
      g[y][x] = wv;
      if (hit_x) m_ext = o_ext;
      if (hit_c) m_chop = o_chop;
      if (hit_k || hit_b) m_cook = o_cook;
    end else if (hit_x) begin
      g[y][x] = (f == G_POT_FIRE) ? G_POT_EMPTY : G_EMPTY;
      m_ext = 0;
      if (hit_c) m_chop = o_chop;
      if (hit_k || hit_b) m_cook = o_cook;
    end else if (hit_c) begin
      g[y][x] = G_ONION_CHOPPED;
      m_chop = 0;
      if (hit_k || hit_b) m_cook = o_cook;
    end else if (hit_k) begin
      g[SY][SX] = G_POT_COOKED;
    end else if (hit_b) begin
      g[SY][SX] = G_POT_FIRE;
    end
    if (srv && m_served < 255) m_served++;
    m_prev = ps; m_px = x; m_py = y;
    m_alarm = FIRE && (g[SY][SX] == G_POT_FIRE);
  endtask

  always @(negedge vsync) model_step();

  // Per-frame compare, mid-frame on the inactive edge.
  always @(posedge vsync) begin : cmp
    int br, bc;
    if (chk_on) begin
      br = -1; bc = -1;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 13; c++)
          if (br < 0 && int'(object_grid[r][c]) != g[r][c]) begin
            br = r; bc = c;
          end
      tests++;
      if (br >= 0) begin
        fails++;
        $display("FAIL grid r%0d c%0d: got %0d want %0d", br, bc,
                 object_grid[br][bc], g[br][bc]);
      end
      tests++;
      if (int'(served_count) != m_served) begin
        fails++;
        $display("FAIL served: got %0d want %0d",
                 served_count, m_served);
      end
      tests++;
      if (fire_alarm != m_alarm) begin
        fails++;
        $display("FAIL alarm: got %0d want %0d",
                 fire_alarm, m_alarm);
      end
    end
  end

  task automatic lit(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cell_is(string name, int r, int c, int exp);
    lit({name, "_dut"}, int'(object_grid[r][c]), exp);
    lit({name, "_mdl"}, g[r][c], exp);
  endtask

  task automatic step(int ps, int x, int y);
    @(posedge vsync);
    reset = 1'b0;
    player_state = 4'(ps);
    x_front = 4'(x);
    y_front = 3'(y);
    @(negedge vsync);
    #1;
  endtask

  task automatic run(int ps, int x, int y, int n);
    for (int i = 0; i < n; i++) step(ps, x, y);
  endtask

  task automatic do_reset();
    @(posedge vsync);
    reset = 1'b1;
    @(negedge vsync);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rps, rx, ry;
    @(negedge vsync); #1;
    @(negedge vsync); #1;
    chk_on = 1'b1;

    // reset layout
    run(P_NOTHING, 0, 0, 5);
    cell_is("rst_onion", 0, 1, G_ONION_WHOLE);
    cell_is("rst_bowl", 0, 2, G_BOWL_EMPTY);
    cell_is("rst_stove", 0, 6, G_POT_EMPTY);
    cell_is("rst_ext", 7, 12, G_EXTINGUISHER);
    cell_is("rst_empty", 4, 4, G_EMPTY);
    lit("rst_served", served_count, 0);
    lit("rst_alarm", fire_alarm, 0);

    // pickup and drop
    step(P_ONION_WHOLE, 1, 0);
    cell_is("pick_onion", 0, 1, G_EMPTY);
    step(P_ONION_WHOLE, 4, 0);
    step(P_NOTHING, 4, 0);
    cell_is("drop_onion", 0, 4, G_ONION_WHOLE);

    // chop with interruption
    run(P_CHOPPING, 4, 0, 119);
    cell_is("chop_119", 0, 4, G_ONION_WHOLE);
    step(P_NOTHING, 4, 0);
    run(P_CHOPPING, 4, 0, 119);
    cell_is("chop_2nd_119", 0, 4, G_ONION_WHOLE);
    step(P_CHOPPING, 4, 0);
    cell_is("chop_120", 0, 4, G_ONION_CHOPPED);

    // cook / burn / extinguish
    step(P_NOTHING, 6, 0);
    step(P_POT_EMPTY, 6, 0);
    cell_is("pick_pot", 0, 6, G_EMPTY);
    step(P_POT_RAW, 6, 0);
    step(P_NOTHING, 6, 0);
    cell_is("raw_on_stove", 0, 6, G_POT_RAW);
    run(P_NOTHING, 6, 0, 299);
    cell_is("cook_299", 0, 6, G_POT_RAW);
    step(P_NOTHING, 6, 0);
    cell_is("cook_300", 0, 6, G_POT_COOKED);
    if (FIRE) begin
      run(P_NOTHING, 6, 0, 299);
      cell_is("burn_599", 0, 6, G_POT_COOKED);
      lit("alarm_599", fire_alarm, 0);
      step(P_NOTHING, 6, 0);
      cell_is("burn_600", 0, 6, G_POT_FIRE);
      lit("alarm_600", fire_alarm, 1);
      step(P_EXT_OFF, 6, 0);
      run(P_EXT_ON, 6, 0, 59);
      cell_is("ext_59", 0, 6, G_POT_FIRE);
      step(P_EXT_ON, 6, 0);
      cell_is("ext_60", 0, 6, G_POT_EMPTY);
      lit("alarm_off", fire_alarm, 0);
      step(P_EXT_ON, 5, 0);
      step(P_NOTHING, 5, 0);
      cell_is("drop_ext", 0, 5, G_EXTINGUISHER);
    end else begin
      run(P_NOTHING, 6, 0, 700);
      cell_is("cook_1000", 0, 6, G_POT_COOKED);
      lit("alarm_1000", fire_alarm, 0);
      step(P_POT_COOKED, 6, 0);
      step(P_POT_EMPTY, 6, 0);
      step(P_NOTHING, 6, 0);
      cell_is("pot_back", 0, 6, G_POT_EMPTY);
    end

    // serve, and drop onto an occupied cell
    step(P_BOWL_FULL, 12, 3);
    step(P_NOTHING, 12, 3);
    lit("served_dut", served_count, 1);
    lit("served_mdl", m_served, 1);
    cell_is("serve_cell", 3, 12, G_EMPTY);
    step(P_ONION_CHOPPED, 2, 0);
    step(P_NOTHING, 2, 0);
    cell_is("drop_occupied", 0, 2, G_BOWL_EMPTY);

    // pickup on the burn-threshold frame
    step(P_POT_EMPTY, 6, 0);
    step(P_POT_RAW, 6, 0);
    step(P_NOTHING, 6, 0);
    run(P_NOTHING, 6, 0, 599);
    cell_is("race_599", 0, 6, G_POT_COOKED);
    step(P_POT_COOKED, 6, 0);
    cell_is("race_pick", 0, 6, G_EMPTY);
    lit("race_alarm", fire_alarm, 0);
    step(P_POT_COOKED, 6, 0);
    step(P_NOTHING, 6, 0);
    step(P_NOTHING, 6, 0);
    cell_is("race_timer_clr", 0, 6, G_POT_COOKED);
    lit("race_alarm2", fire_alarm, 0);
    step(P_POT_COOKED, 6, 0);
    step(P_NOTHING, 8, 0);
    cell_is("drop_cooked", 0, 8, G_POT_COOKED);

    // reset mid-cook
    step(P_POT_RAW, 6, 0);
    step(P_NOTHING, 6, 0);
    run(P_NOTHING, 6, 0, 100);
    do_reset();
    cell_is("mid_rst_stove", 0, 6, G_POT_EMPTY);
    cell_is("mid_rst_cell", 0, 8, G_EMPTY);
    cell_is("mid_rst_onion", 0, 1, G_ONION_WHOLE);
    lit("mid_rst_served", served_count, 0);
    run(P_NOTHING, 0, 0, 3);

    // random frames
    rps = P_NOTHING; rx = 0; ry = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) rps = $urandom_range(10);
      if ($urandom_range(15) == 0) begin
        case ($urandom_range(5))
          0: begin rx = 1;  ry = 0; end
          1: begin rx = 2;  ry = 0; end
          2: begin rx = SX; ry = SY; end
          3: begin rx = VX; ry = VY; end
          4: begin
            rx = $urandom_range(15, 13);
            ry = $urandom_range(7);
          end
          default: begin
            rx = $urandom_range(12);
            ry = $urandom_range(7);
          end
        endcase
      end
      if ($urandom_range(499) == 0) do_reset();
      else step(rps, rx, ry);
    end

    @(posedge vsync); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/grid_update.md
# grid_update

Downstream of the player-state stage: it turns player-state transitions into edits of the kitchen object grid and runs the per-frame chop, cook, burn and extinguish timers. It owns the registered `object_grid` that the player-state stage and the sprite renderer read. One update happens per frame, on the same vsync edge as the player-state stage. At most one grid cell is written per frame.

## Interface

Parameters:
- `CHOP_FRAMES`, 120: frames of continuous chopping to turn a whole onion into a chopped onion.
- `COOK_FRAMES`, 300: frames on the stove to turn a raw pot into a cooked pot.
- `BURN_FRAMES`, 600: frames on the stove (counted from raw) until a pot catches fire.
- `EXT_FRAMES`, 60: frames of extinguisher spray to put out a pot fire.
- `STOVE_X`, 6 / `STOVE_Y`, 0: stove cell.
- `SERVE_X`, 12 / `SERVE_Y`, 3: serving-window cell.

Ports:
- `vsync`, in, 1: clock. All logic updates on the negedge.
- `reset`, in, 1: synchronous, active-high.
- `player_state`, in, 4: P_* code from the player-state stage.
- `x_front`, in, 4: column of the cell in front of the player.
- `y_front`, in, 3: row of the cell in front of the player.
- `object_grid`, out, [7:0][12:0][3:0]: G_* code per cell, indexed [row][col].
- `served_count`, out, 8: number of full bowls served. Saturates at 255.
- `fire_alarm`, out, 1: high while the stove cell holds G_POT_FIRE.

## Operation

- `prev_state` register: holds last frame's `player_state`. A transition is the pair (`prev_state`, `player_state`).
- Front cell F = `object_grid[y_front][x_front]`.
- F is invalid when `x_front` > 12 or `y_front` > 7. An invalid F gets no player writes. Timers still run.
- Player writes. These are mutually exclusive and decoded from the transition:
  - Pickup: NOTHING → ONION_WHOLE / ONION_CHOPPED / POT_EMPTY / POT_RAW / POT_COOKED / BOWL_EMPTY / BOWL_FULL / EXT_OFF, and F holds the matching G_ code. Write F ← G_EMPTY.
  - Drop: any carry state (EXT_ON counts as EXT_OFF) → NOTHING, and F = G_EMPTY. Write F ← the matching G_ code.
    - Exception: BOWL_FULL dropped on the SERVE cell leaves the cell G_EMPTY and increments `served_count`.
  - POT_EMPTY → POT_RAW, F = G_ONION_CHOPPED: write F ← G_EMPTY.
  - BOWL_EMPTY → BOWL_FULL, F = G_POT_COOKED: write F ← G_POT_EMPTY.
  - POT_COOKED → POT_EMPTY, F = G_BOWL_EMPTY: write F ← G_BOWL_FULL.
  - A drop onto a non-empty F writes nothing.
- Chop timer (10-bit):
  - Increments while `player_state` = CHOPPING and F = G_ONION_WHOLE.
  - Clears on any other frame, or when (`x_front`, `y_front`) changes.
  - On reaching `CHOP_FRAMES`: write F ← G_ONION_CHOPPED and clear the timer.
- Cook timer (10-bit):
  - Increments while the stove cell is G_POT_RAW or G_POT_COOKED. Clears otherwise.
  - Equals `COOK_FRAMES` while the cell is RAW: stove ← G_POT_COOKED.
  - Equals `BURN_FRAMES`: stove ← G_POT_FIRE.
  - Saturates at `BURN_FRAMES`.
- Extinguish timer (6-bit):
  - Increments while `player_state` = EXT_ON and F = G_POT_FIRE or G_FIRE.
  - Clears otherwise.
  - On reaching `EXT_FRAMES`: write F ← G_POT_EMPTY if F was G_POT_FIRE, else G_EMPTY. Clear the timer.
- Write priority within one frame: player write > extinguish > chop > cook. A lower-priority write that loses is discarded; its timer keeps its value.
- Reset layout:
  - Every cell is G_EMPTY except:
  - (row 0, col 1) = G_ONION_WHOLE
  - (row 0, col 2) = G_BOWL_EMPTY
  - stove = G_POT_EMPTY
  - (row 7, col 12) = G_EXTINGUISHER

## Timing

- Every output is registered.
- A grid edit appears on the same negedge that first sees the new `player_state`. That is one frame after the player-state stage changed state.
- Reset values:
  - `object_grid` = reset layout.
  - `served_count` = 0.
  - `fire_alarm` = 0.
  - `prev_state` = P_NOTHING.
  - All timers = 0.
- `reset` asserted mid-cook or mid-chop: the grid returns to the reset layout and the timers clear on that edge.
- `fire_alarm` follows the registered stove cell, so it is valid on the same edge the FIRE code is written.

## Configuration

- `GRID_FIRE_EN` defined:
  - Burning is active.
  - The extinguish timer is active.
  - `fire_alarm` behaves as described above.
- Not defined:
  - The cook timer saturates at `COOK_FRAMES`, so a cooked pot never burns.
  - The extinguish logic is removed.
  - `fire_alarm` is tied to 0.

## Test plan

- Reset, then hold NOTHING for 5 frames → grid equals the reset layout; `served_count` = 0.
- Front = (0,1), NOTHING → ONION_WHOLE → cell (0,1) = G_EMPTY on the next edge. Front = (0,4) empty, then → NOTHING → (0,4) = G_ONION_WHOLE.
- Whole onion in F, CHOPPING for 119 frames then 1 frame of NOTHING, then 120 frames of CHOPPING → no change after the 119 frames; G_ONION_CHOPPED exactly on the 120th frame of the second run.
- Place G_POT_RAW on the stove, then idle → G_POT_COOKED on frame 300. With `GRID_FIRE_EN`: G_POT_FIRE and `fire_alarm` = 1 on frame 600. Then EXT_ON facing the stove for 60 frames → G_POT_EMPTY, `fire_alarm` = 0. Without `GRID_FIRE_EN`: the pot stays COOKED through frame 1000.
- Drop BOWL_FULL facing (3,12) → cell stays G_EMPTY, `served_count` 0 → 1. Drop into an occupied cell → no write.
- Player pickup of the cooked pot on the same frame the burn threshold hits → stove = G_EMPTY (player write wins); cook timer clears on the next edge.
